// File: rtl/even_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : even_seq_pkg
//  Description : Shared types and constants for the even-value sequence
//                run controller (state encoding, default widths/limits).
//  Revision    : 1.0  - initial release
// ============================================================================
package even_seq_pkg;

    // Default generator value width and last legal value before wrap to 0.
    localparam int unsigned C_WIDTH   = 4;
    localparam int unsigned C_MAX_VAL = 8;

    // Width of the run-length field and the remaining-values counter.
    localparam int unsigned C_LEN_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage : even_seq_pkg
`default_nettype wire

// File: rtl/even_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : even_seq_ctrl_if
//  Description : Valid/ready output stream from the run controller to the
//                downstream consumer.
//                  out_valid : value on out_data is valid
//                  out_data  : generator value (0 while out_valid is low)
//                  out_ready : consumer accepts the value this cycle
//                master = controller side, slave = consumer side.
//  Revision    : 1.0  - initial release
// ============================================================================
interface even_seq_ctrl_if
    import even_seq_pkg::*;
#(
    parameter int unsigned WIDTH = C_WIDTH
) ();

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface : even_seq_ctrl_if
`default_nettype wire

// File: rtl/run_counter.sv
`default_nettype none
// ============================================================================
//  Module      : run_counter
//  Description : Loadable down-counter holding the number of values still to
//                be emitted in the current run. Saturates at zero.
//                  clk      : clock, rising edge
//                  rst      : asynchronous active-high reset (count -> 0)
//                  load     : load load_val (wins over dec)
//                  load_val : new count
//                  dec      : decrement by one (ignored at zero)
//                  is_one   : count == 1
//                  is_zero  : count == 0
//  Revision    : 1.0  - initial release
// ============================================================================
module run_counter
    import even_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [C_LEN_W-1:0] load_val,
    input  logic               dec,
    output logic               is_one,
    output logic               is_zero
);

    logic [C_LEN_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign is_zero = (r_count == '0);
    assign is_one  = (r_count == C_LEN_W'(1));

endmodule : run_counter
`default_nettype wire

// File: rtl/even_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : even_seq_ctrl
//  Description : Run controller for the even-value sequence generator. A start
//                clears the generator, then emits len generator values over a
//                valid/ready stream (stepping the generator once per accepted
//                value) and pulses done. Illegal generator values seen while
//                emitting set a sticky err flag.
//                  clk      : clock, rising edge
//                  reset    : asynchronous active-high reset
//                  start    : run request (sampled only when idle)
//                  abort    : cancel current run (priority over start)
//                  len      : number of values to emit, latched on start
//                  gen_val  : current generator output
//                  gen_clr  : synchronous clear to the generator
//                  gen_load : step the generator at the next edge
//                  out_if   : valid/ready output stream (master)
//                  busy     : run in progress
//                  done     : one-cycle pulse at normal end of run
//                  err      : sticky illegal-value flag
//  Revision    : 1.0  - initial release
// ============================================================================
module even_seq_ctrl
    import even_seq_pkg::*;
#(
    parameter int unsigned WIDTH   = C_WIDTH,
    parameter int unsigned MAX_VAL = C_MAX_VAL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [C_LEN_W-1:0] len,
    input  logic [WIDTH-1:0]   gen_val,
    output logic               gen_clr,
    output logic               gen_load,
    even_seq_ctrl_if.master    out_if,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_t r_state;
    state_t w_next;

    logic   r_gen_clr;
    logic   r_out_valid;
    logic   r_busy;
    logic   r_done;
    logic   r_err;

    logic   w_start_ok;
    logic   w_xfer;
    logic   w_illegal;
    logic   w_is_one;
    logic   w_is_zero;

    assign w_start_ok = (r_state == ST_IDLE) && start && !abort;
    assign w_xfer     = r_out_valid && out_if.out_ready;
    assign w_illegal  = gen_val[0] || (32'(gen_val) > MAX_VAL);

    run_counter u_run_counter (
        .clk      (clk),
        .rst      (reset),
        .load     (w_start_ok),
        .load_val (len),
        .dec      (w_xfer),
        .is_one   (w_is_one),
        .is_zero  (w_is_zero)
    );

    // Next-state decision; abort always returns to IDLE from an active state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_next = ST_CLR;
            ST_CLR: begin
                if (abort)          w_next = ST_IDLE;
                else if (w_is_zero) w_next = ST_DONE;
                else                w_next = ST_EMIT;
            end
            ST_EMIT: begin
                if (abort)                   w_next = ST_IDLE;
                else if (w_xfer && w_is_one) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State plus registered outputs. Outputs are decoded from the next state
    // so they are aligned with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_gen_clr   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_gen_clr   <= (w_next == ST_CLR);
            r_out_valid <= (w_next == ST_EMIT);
            r_busy      <= (w_next != ST_IDLE);
            r_done      <= (w_next == ST_DONE);
            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if ((r_state == ST_EMIT) && w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    // gen_load follows the handshake directly so the generator steps on the
    // same edge the consumer takes the value.
    assign gen_load         = w_xfer;
    assign gen_clr          = r_gen_clr;
    assign out_if.out_valid = r_out_valid;
    assign out_if.out_data  = r_out_valid ? gen_val : '0;
    assign busy             = r_busy;
    assign done             = r_done;
    assign err              = r_err;

endmodule : even_seq_ctrl
`default_nettype wire

// File: tb/tb_even_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_even_seq_ctrl
//  Description : Self-checking bench for even_seq_ctrl. Contains a generator
//                model driven by gen_clr/gen_load, a run-level reference
//                model, a per-cycle compare process, directed scenarios with
//                literal expectations and a randomized phase.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_even_seq_ctrl;
    import even_seq_pkg::*;

    localparam int W    = 4;
    localparam int MAXV = 8;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [3:0]   len   = 4'd0;
    logic [W-1:0] gen_val;
    logic         gen_clr, gen_load, busy, done, err;
    logic         inject = 1'b0;
    logic [W-1:0] g_reg;

    even_seq_ctrl_if #(.WIDTH(W)) sif ();

    even_seq_ctrl #(.WIDTH(W), .MAX_VAL(MAXV)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .len      (len),
        .gen_val  (gen_val),
        .gen_clr  (gen_clr),
        .gen_load (gen_load),
        .out_if   (sif.master),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Even-value generator: 0,2,..,MAXV,0,...
    always @(posedge clk or posedge reset) begin
        if (reset)         g_reg <= '0;
        else if (gen_clr)  g_reg <= '0;
        else if (gen_load) g_reg <= (int'(g_reg) >= MAXV) ? '0 : g_reg + 4'd2;
    end
    assign gen_val = inject ? 4'd3 : g_reg;

    // ---------------- checking bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // A run is active from start acceptance; the first active cycle clears the
    // generator, then values are owed until m_left reaches 0; a normally
    // finished run spends one cycle in the done pulse.
    bit m_active  = 1'b0;
    bit m_cleared = 1'b0;
    bit m_done    = 1'b0;
    bit m_err     = 1'b0;
    int m_left    = 0;
    int m_idx     = 0;

    function automatic bit exp_valid();
        return m_active && m_cleared && (m_left > 0);
    endfunction

    always @(posedge clk or posedge reset) begin : model
        bit v, x;
        if (reset) begin
            m_active = 0; m_cleared = 0; m_done = 0; m_err = 0; m_left = 0; m_idx = 0;
        end else begin
            v = exp_valid();
            x = v && sif.out_ready;
            if (v && (gen_val[0] || int'(gen_val) > MAXV)) m_err = 1;
            if (!m_active && !m_done) begin
                if (start && !abort) begin
                    m_active = 1; m_cleared = 0; m_left = int'(len); m_idx = 0; m_err = 0;
                end
            end else if (m_done) begin
                m_done = 0;
            end else begin
                if (x) begin m_idx++; m_left--; end
                if (abort) m_active = 0;
                else if (!m_cleared) begin
                    m_cleared = 1;
                    if (m_left == 0) begin m_active = 0; m_done = 1; end
                end else if (x && m_left == 0) begin
                    m_active = 0; m_done = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : compare
        bit ev;
        int ed;
        if (!reset) begin
            ev = exp_valid();
            ed = ev ? (inject ? 3 : (2 * m_idx) % (MAXV + 2)) : 0;
            chk("busy",      32'(busy),          32'(m_active || m_done));
            chk("done",      32'(done),          32'(m_done));
            chk("gen_clr",   32'(gen_clr),       32'(m_active && !m_cleared));
            chk("out_valid", 32'(sif.out_valid), 32'(ev));
            chk("gen_load",  32'(gen_load),      32'(ev && sif.out_ready));
            chk("out_data",  32'(sif.out_data),  32'(ed));
            chk("err",       32'(err),           32'(m_err));
        end
    end

    // ---------------- monitor for literal checks ----------------
    logic [3:0] got[$];
    int n_load = 0, n_busy = 0, n_done = 0, n_valid = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (sif.out_valid && sif.out_ready) got.push_back(sif.out_data);
            if (gen_load)      n_load++;
            if (busy)          n_busy++;
            if (done)          n_done++;
            if (sif.out_valid) n_valid++;
        end
    end

    function automatic logic [31:0] pack(input logic [3:0] q[$]);
        logic [31:0] r = '0;
        foreach (q[i]) r = (r << 4) | 32'(q[i]);
        return r;
    endfunction

    // ---------------- consumer ready drive ----------------
    int rmode = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: random
    int rcnt  = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       sif.out_ready = 1'b1;
            1:       begin sif.out_ready = (rcnt % 3 == 0); rcnt++; end
            default: sif.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got.delete();
        n_load = 0; n_busy = 0; n_done = 0; n_valid = 0;
    endtask

    // Pulse start for one edge; returns at the cycle the run is in CLR.
    task automatic do_start(input int l);
        start = 1'b1;
        len   = 4'(l);
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int b = 0;
        while ((busy || done) && b < 100) begin cyc(1); b++; end
        if (b >= 100) chk("idle_timeout", 32'(1), 32'(0));
        cyc(1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        sif.out_ready = 1'b1;
        #1;
        // Reset state
        chk("rst_busy",      32'(busy),          32'(0));
        chk("rst_done",      32'(done),          32'(0));
        chk("rst_err",       32'(err),           32'(0));
        chk("rst_gen_clr",   32'(gen_clr),       32'(0));
        chk("rst_gen_load",  32'(gen_load),      32'(0));
        chk("rst_out_valid", 32'(sif.out_valid), 32'(0));
        chk("rst_out_data",  32'(sif.out_data),  32'(0));
        cyc(2);
        @(negedge clk) reset = 1'b0;
        cyc(2);

        // len=5, always ready
        rmode = 0; clear_mon();
        do_start(5); wait_idle();
        chk("len5_seq",  pack(got),      32'h02468);
        chk("len5_done", 32'(n_done),    32'(1));
        chk("len5_busy", 32'(n_busy),    32'(7));
        chk("len5_err",  32'(err),       32'(0));

        // len=7, wrap through 0
        clear_mon();
        do_start(7); wait_idle();
        chk("len7_seq",  pack(got),      32'h0246802);
        chk("len7_load", 32'(n_load),    32'(7));

        // len=4 with stalls
        rmode = 1; rcnt = 0; clear_mon();
        do_start(4); wait_idle();
        chk("stall_seq", pack(got),      32'h0246);
        chk("stall_cnt", 32'(got.size()), 32'(4));
        rmode = 0;

        // len=0
        clear_mon();
        do_start(0); wait_idle();
        chk("len0_busy",  32'(n_busy),   32'(2));
        chk("len0_done",  32'(n_done),   32'(1));
        chk("len0_valid", 32'(n_valid),  32'(0));

        // abort after second transfer of a len=6 run
        clear_mon();
        do_start(6);
        begin
            int b = 0;
            while (got.size() < 2 && b < 50) begin cyc(1); b++; end
            if (b >= 50) chk("abort_wait_timeout", 32'(1), 32'(0));
        end
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_idle", 32'(busy), 32'(0));
        cyc(2);
        chk("abort_seq",  pack(got),   32'h024);
        chk("abort_done", 32'(n_done), 32'(0));

        clear_mon();
        do_start(3); wait_idle();
        chk("len3_seq",  pack(got),   32'h024);
        chk("len3_done", 32'(n_done), 32'(1));

        // illegal value during EMIT
        clear_mon();
        do_start(5);
        cyc(2);
        inject = 1'b1;
        cyc(1);
        inject = 1'b0;
        chk("err_set", 32'(err), 32'(1));
        wait_idle();
        chk("err_after_done", 32'(err),    32'(1));
        chk("err_run_done",   32'(n_done), 32'(1));
        do_start(1);
        chk("err_cleared", 32'(err), 32'(0));
        wait_idle();

        // reset mid-run
        do_start(6);
        cyc(2);
        #2 reset = 1'b1;
        #1;
        chk("mrst_busy",      32'(busy),          32'(0));
        chk("mrst_out_valid", 32'(sif.out_valid), 32'(0));
        chk("mrst_out_data",  32'(sif.out_data),  32'(0));
        chk("mrst_gen_clr",   32'(gen_clr),       32'(0));
        chk("mrst_done",      32'(done),          32'(0));
        @(negedge clk) reset = 1'b0;
        cyc(2);

        // randomized phase
        rmode = 2;
        for (int i = 0; i < 800; i++) begin
            start  = ($urandom_range(0, 5) == 0);
            len    = 4'($urandom_range(0, 15));
            abort  = ($urandom_range(0, 24) == 0);
            inject = ($urandom_range(0, 49) == 0);
            cyc(1);
        end
        start = 1'b0; abort = 1'b0; inject = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_even_seq_ctrl
`default_nettype wire

// File: doc/even_seq_ctrl.md
# even_seq_ctrl

Run controller for the even-value sequence generator (0, 2, 4, 6, 8, wrap to 0). On a start pulse it clears the generator, steps it once per accepted output over a valid/ready stream for a programmed number of values, then pulses done. It also checks every generator value for legality. It sits between the generator (whose load/clear it drives) and the downstream consumer.

## Interface
- WIDTH, 4: generator value width in bits.
- MAX_VAL, 8: last legal value before the generator wraps to 0; must be even.
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE and all outputs to 0.
- start  input  1  run request; sampled only in IDLE.
- abort  input  1  cancel the current run; takes priority over start.
- len  input  4  number of values to emit (0–15); latched on accepted start.
- gen_val  input  WIDTH  current generator output.
- gen_clr  output  1  synchronous clear to the generator.
- gen_load  output  1  advance the generator one step at the next edge.
- out_valid  output  1  out_data is valid.
- out_data  output  WIDTH  equals gen_val while out_valid is high.
- out_ready  input  1  consumer accepts the value.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when a run ends normally.
- err  output  1  sticky illegal-value flag; cleared by an accepted start.

## Operation
- States:
  - IDLE: no outputs asserted. start=1 and abort=0 → CLR; latch len into remaining; clear err.
  - CLR: gen_clr=1 for one cycle. If remaining==0 → DONE, else → EMIT.
  - EMIT: out_valid=1 and out_data=gen_val. A transfer (out_valid & out_ready) asserts gen_load combinationally and decrements remaining. A transfer with remaining==1 → DONE; otherwise stay in EMIT.
  - DONE: done=1 for one cycle, then → IDLE.
- abort=1 in CLR, EMIT or DONE → IDLE at the next edge. No done pulse; err is kept. In the abort cycle gen_load and out_valid are still driven normally, and a transfer in that cycle counts as delivered.
- start while busy is ignored, including in DONE.
- In EMIT the block sets err if gen_val is odd or gen_val > MAX_VAL. err stays set through the run and after it, until the next accepted start.
- remaining is 4-bit unsigned and never decremented below 0.
- gen_load is never asserted without a transfer. gen_clr and gen_load are never high together.

## Timing
- Reset values: state=IDLE, remaining=0, err=0. All outputs are 0, and out_data=0 while out_valid=0.
- start high at edge N → CLR during cycle N+1 → first out_valid in cycle N+2, carrying value 0.
- With out_ready held high: one value per cycle, and done rises the cycle after the last transfer.
- Total run length with no stalls: len+3 cycles from the start edge to return to IDLE. For len=0: CLR, DONE, IDLE.
- out_valid is held high and out_data is stable while out_ready is low. No value is dropped or repeated.
- Reset asserted mid-run: IDLE immediately (asynchronous). No done pulse; err cleared.

## Structure
- Package even_seq_pkg holds:
  - the state enum (IDLE, CLR, EMIT, DONE);
  - the default WIDTH and MAX_VAL constants;
  - a LEN_W=4 constant.
- Sub-module run_counter: 4-bit loadable down-counter with load, dec and is_one/is_zero outputs, asynchronous active-high reset.
- The FSM, legality check and handshake logic stay in the top module.

## Test plan
- len=5, out_ready=1: out_data 0, 2, 4, 6, 8 on consecutive cycles from start+2; done one cycle later; busy low after that; err=0.
- len=7: out_data 0, 2, 4, 6, 8, 0, 2 (wrap through 0); exactly 7 gen_load pulses.
- len=4, out_ready toggling 1, 0, 0, 1, …: out_data holds 2 through the stall; the sequence delivered is 0, 2, 4, 6 with no duplicates.
- len=0: busy for 2 cycles, done pulses, out_valid never asserted.
- abort asserted after the 2nd transfer of a len=6 run: IDLE next cycle, no done. A following start with len=3 yields 0, 2, 4.
- Force gen_val=3 during EMIT: err=1 and stays 1 through done, then clears on the next start. Reset mid-run clears all outputs immediately.
